dpram_be_clr: RTL and testbench
===============================

# dpram_be_clr

Single-clock true dual-port RAM with per-port byte enables, a priority-based write-collision resolver, write-first read-during-write forwarding, synchronous reads with valid strobes and a built-in sequential clear engine. It is the parametrised successor to the team's register-based dual-port RAM. It serves as the shared sample/coefficient buffer between the pulse-oximetry acquisition path and the processing datapath, and can stand in as the behavioural model for a real SRAM macro.

## Interface
- WIDTH, 16: data width in bits; must be a multiple of 8.
- DEPTHBIT, 4: address width; depth is 2^DEPTHBIT words.
- PRIO_B, 0: collision priority; 0 means port A wins, 1 means port B wins.
- CLR_VALUE, 0: word written to every location by the clear engine.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- clr_req  in  1  start a full-memory clear; honoured only while ready=1.
- ready  out  1  high when the ports accept accesses.
- addr_a / addr_b  in  DEPTHBIT  port address.
- we_a / we_b  in  1  write enable.
- be_a / be_b  in  WIDTH/8  byte enables for the write; bit i covers bits [8i+7:8i].
- wdata_a / wdata_b  in  WIDTH  write data.
- re_a / re_b  in  1  read enable.
- rdata_a / rdata_b  out  WIDTH  read data; holds its value between reads.
- rvalid_a / rvalid_b  out  1  one-cycle strobe marking new rdata.
- coll  out  1  one-cycle pulse flagging a same-address overlapping-byte write collision.

## Operation
- Two states, CLEAR and READY.
  - Asynchronous reset enters CLEAR with the clear counter at 0.
  - In CLEAR, each cycle writes CLR_VALUE to address counter, then increments the counter.
  - When the counter reaches DEPTH-1, that location is written and the state moves to READY.
  - In READY, clr_req=1 moves the state to CLEAR with counter 0 on the next edge.
  - clr_req is ignored while in CLEAR; a clear is never restarted.
- ready=1 exactly in READY. While ready=0, we_*, re_* and be_* are ignored: no array write, no rvalid, no coll.
- Writes in READY with we_x=1 update only the bytes whose be_x bit is set.
  - Different addresses: both ports write.
  - Same address: bytes enabled by only one port take that port's data.
  - Same address: bytes enabled by both ports take the priority port's data (PRIO_B). coll pulses on the next cycle.
  - we_x with be_x all-zero is a no-op.
- Reads: re_x=1 samples ram[addr_x] as it is after this edge's writes (write-first). This applies to both same-port and cross-port forwarding, merged per byte.
- Memory contents are not reset by rst_n; only the clear engine initialises them.
- Reset values: ready=0, rdata_a=rdata_b=0, rvalid_a=rvalid_b=0, coll=0, state CLEAR, counter 0.
- Reset asserted mid-clear or mid-access aborts immediately. The output pipeline is flushed and the clear restarts from 0 on release.

## Timing
- Read latency is 1 cycle: re at edge N gives rdata and rvalid=1 after edge N+1 (with DPRAM_OUTREG_EN, after edge N+2).
- Back-to-back reads every cycle are allowed; each produces its own rvalid.
- Clear takes DEPTH cycles: the first edge after rst_n rises writes address 0, and the DEPTH-th edge writes DEPTH-1 and sets ready=1.
- After clr_req in READY, ready drops on the next edge. It returns high DEPTH edges later, so ready is low for exactly DEPTH cycles.
- A read issued on the last READY cycle before a clear still completes and delivers rvalid.
- coll rises one edge after the colliding write and lasts one cycle.
- Address wrap is implicit; there is no out-of-range address.

## Configuration
- DPRAM_OUTREG_EN defined: adds an output register stage after the read register.
  - rdata/rvalid latency becomes 2 cycles.
  - coll latency is unchanged.
  - The reset flushes both stages to 0.
- Not defined: single read register, latency 1.

## Structure
- Shared package dpram_pkg holds:
  - the state typedef (CLEAR, READY);
  - a constant function for the byte count, WIDTH/8;
  - a byte-merge function (old word, new word, byte mask) used by both ports and by the forwarding path.
- Sub-module dpram_clear_ctrl contains the state machine and the clear counter. It outputs ready, clr_we and clr_addr.
- The top level holds the array, the collision resolver and the read pipeline.

## Test plan
- Reset release with DEPTHBIT=4: ready=0 for 16 edges, then 1. Reading every address returns CLR_VALUE and rvalid pulses once per read.
- Write A addr 3 data 0xBEEF with be=2'b11, then read B addr 3 with re_b=1: rdata_b=0xBEEF and rvalid_b=1 one cycle later (two cycles with DPRAM_OUTREG_EN).
- Same-edge write to addr 5: A writes 0x1111 with be=2'b11, B writes 0x2222 with be=2'b10, PRIO_B=0. Result is word=0x1111 and coll=1 for one cycle. Repeat with PRIO_B=1: word=0x2211.
- Same-edge write A addr 7 0xAAAA be=2'b01 with read B addr 7 (location previously 0x0000): rdata_b=0x00AA, which checks write-first forwarding.
- clr_req=1 in READY after filling memory: ready low for exactly 16 cycles, all locations read back CLR_VALUE, and writes and reads issued during the clear leave no effect and raise no rvalid.
- rst_n pulsed low at counter=8 mid-clear: outputs return to reset values at once and the clear restarts from address 0 on release, taking 16 cycles.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared definitions for the byte-enabled dual-port RAM family.
//   dpram_state_e : clear-engine states (CLEAR, READY)
//   byte_count()  : number of byte lanes in a data word
//   byte_merge()  : per-byte merge of a new word into an old word
// Merge operates on a MAX_W-bit container so one function serves every
// instance width; callers zero-extend in and truncate out.
package dpram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dpram_state_e;

  localparam int MAX_W = 256;
  localparam int MAX_B = MAX_W / 8;

  function automatic int byte_count(input int width);
    return width / 8;
  endfunction

  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w,
                                                  input logic [MAX_W-1:0] new_w,
                                                  input logic [MAX_B-1:0] mask);
    logic [MAX_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_B; i++) begin
      if (mask[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dpram_be_clr_if.sv
// Port bundle for dpram_be_clr.
//   clr_req, ready                          : clear request / access enable
//   addr_x, we_x, be_x, wdata_x, re_x       : per-port access request
//   rdata_x, rvalid_x                       : per-port read return
//   coll                                    : write-collision pulse
// master drives requests, slave (the RAM) drives responses.
interface dpram_be_clr_if import dpram_pkg::*; #(
  parameter int WIDTH    = 16,
  parameter int DEPTHBIT = 4
);
  localparam int BYTES = byte_count(WIDTH);

  logic                clr_req;
  logic                ready;
  logic [DEPTHBIT-1:0] addr_a;
  logic [DEPTHBIT-1:0] addr_b;
  logic                we_a;
  logic                we_b;
  logic [BYTES-1:0]    be_a;
  logic [BYTES-1:0]    be_b;
  logic [WIDTH-1:0]    wdata_a;
  logic [WIDTH-1:0]    wdata_b;
  logic                re_a;
  logic                re_b;
  logic [WIDTH-1:0]    rdata_a;
  logic [WIDTH-1:0]    rdata_b;
  logic                rvalid_a;
  logic                rvalid_b;
  logic                coll;

  modport master (
    output clr_req, addr_a, addr_b, we_a, we_b, be_a, be_b,
           wdata_a, wdata_b, re_a, re_b,
    input  ready, rdata_a, rdata_b, rvalid_a, rvalid_b, coll
  );

  modport slave (
    input  clr_req, addr_a, addr_b, we_a, we_b, be_a, be_b,
           wdata_a, wdata_b, re_a, re_b,
    output ready, rdata_a, rdata_b, rvalid_a, rvalid_b, coll
  );

endinterface

// File: rtl/dpram_clear_ctrl.sv
// Clear engine: walks every address writing the clear value, then opens
// the ports. A clear request is only accepted while READY and a running
// clear is never restarted.
//   clk, rst_n : clock, async active-low reset (enters CLEAR, counter 0)
//   clr_req    : request a full-memory clear
//   ready      : registered, high exactly while in READY
//   clr_we     : clear write strobe for this cycle
//   clr_addr   : address being cleared this cycle
module dpram_clear_ctrl import dpram_pkg::*; #(
  parameter int DEPTHBIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_req,
  output logic                ready,
  output logic                clr_we,
  output logic [DEPTHBIT-1:0] clr_addr
);

  localparam logic [DEPTHBIT-1:0] LAST_ADDR = {DEPTHBIT{1'b1}};

  dpram_state_e        state_r;
  dpram_state_e        state_next_s;
  logic [DEPTHBIT-1:0] cnt_r;
  logic [DEPTHBIT-1:0] cnt_next_s;
  logic                ready_r;

  // Next-state, counter and clear-strobe decode.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    clr_we       = 1'b0;
    clr_addr     = cnt_r;
    case (state_r)
      CLEAR: begin
        clr_we = 1'b1;
        if (cnt_r == LAST_ADDR) begin
          state_next_s = READY;
          cnt_next_s   = {DEPTHBIT{1'b0}};
        end else begin
          cnt_next_s   = cnt_r + DEPTHBIT'(1);
        end
      end
      READY: begin
        if (clr_req) begin
          state_next_s = CLEAR;
          cnt_next_s   = {DEPTHBIT{1'b0}};
        end else begin
          state_next_s = READY;
        end
      end
      default: begin
        state_next_s = CLEAR;
        cnt_next_s   = {DEPTHBIT{1'b0}};
      end
    endcase
  end

  // State, counter and ready register; ready tracks the next state so it
  // is high exactly while the state register holds READY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= CLEAR;
      cnt_r   <= {DEPTHBIT{1'b0}};
      ready_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      ready_r <= (state_next_s == READY);
    end
  end

  assign ready = ready_r;

endmodule

// File: rtl/dpram_be_clr.sv
// Single-clock true dual-port RAM with byte enables, same-address write
// collision resolution, write-first forwarding, registered reads with
// valid strobes, and a sequential clear engine.
//   clk, rst_n : clock, async active-low reset (array contents untouched)
//   bus        : dpram_be_clr_if slave port (requests, read returns, coll)
// Parameters: WIDTH (multiple of 8), DEPTHBIT, PRIO_B (0: A wins,
// 1: B wins on overlapping bytes), CLR_VALUE.
// Optional macro DPRAM_OUTREG_EN adds a second read output register
// (rdata/rvalid latency 2; coll latency stays 1).
module dpram_be_clr import dpram_pkg::*; #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTHBIT  = 4,
  parameter int               PRIO_B    = 0,
  parameter logic [WIDTH-1:0] CLR_VALUE = {WIDTH{1'b0}}
) (
  input  logic           clk,
  input  logic           rst_n,
  dpram_be_clr_if.slave  bus
);

  localparam int BYTES = byte_count(WIDTH);
  localparam int DEPTH = 32'd1 << DEPTHBIT;

  function automatic logic [WIDTH-1:0] merge_w(input logic [WIDTH-1:0] old_w,
                                               input logic [WIDTH-1:0] new_w,
                                               input logic [BYTES-1:0] mask);
    logic [MAX_W-1:0] res;
    res = byte_merge(MAX_W'(old_w), MAX_W'(new_w), MAX_B'(mask));
    return res[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0]    mem_r [DEPTH];

  logic                ready_s;
  logic                clr_we_s;
  logic [DEPTHBIT-1:0] clr_addr_s;

  logic [BYTES-1:0]    ma_s;
  logic [BYTES-1:0]    mb_s;
  logic [BYTES-1:0]    eff_a_s;
  logic [BYTES-1:0]    eff_b_s;
  logic [BYTES-1:0]    xa_s;
  logic [BYTES-1:0]    xb_s;
  logic                same_s;
  logic [WIDTH-1:0]    pa1_s;
  logic [WIDTH-1:0]    pb1_s;
  logic [WIDTH-1:0]    post_a_s;
  logic [WIDTH-1:0]    post_b_s;
  logic                coll_d_s;
  logic                rd_a_en_s;
  logic                rd_b_en_s;

  logic [WIDTH-1:0]    rdata_a_r;
  logic [WIDTH-1:0]    rdata_b_r;
  logic                rvalid_a_r;
  logic                rvalid_b_r;
  logic                coll_r;

  dpram_clear_ctrl #(
    .DEPTHBIT (DEPTHBIT)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (bus.clr_req),
    .ready    (ready_s),
    .clr_we   (clr_we_s),
    .clr_addr (clr_addr_s)
  );

  // Collision resolution and post-write word for each port address.
  // eff_x are the byte lanes each port really writes; when both ports hit
  // the same word the losing port is masked off the shared lanes, so the
  // two merges below can be applied in either order. xa/xb carry the other
  // port's lanes into this port's word when the addresses match, which
  // gives write-first forwarding for both same-port and cross-port reads.
  always_comb begin
    if (ready_s && bus.we_a) begin
      ma_s = bus.be_a;
    end else begin
      ma_s = {BYTES{1'b0}};
    end
    if (ready_s && bus.we_b) begin
      mb_s = bus.be_b;
    end else begin
      mb_s = {BYTES{1'b0}};
    end
    same_s  = (bus.addr_a == bus.addr_b);
    eff_a_s = ma_s;
    eff_b_s = mb_s;
    if (same_s) begin
      if (PRIO_B != 0) begin
        eff_a_s = ma_s & ~mb_s;
      end else begin
        eff_b_s = mb_s & ~ma_s;
      end
      xa_s = eff_b_s;
      xb_s = eff_a_s;
    end else begin
      xa_s = {BYTES{1'b0}};
      xb_s = {BYTES{1'b0}};
    end
    pa1_s     = merge_w(mem_r[bus.addr_a], bus.wdata_a, eff_a_s);
    post_a_s  = merge_w(pa1_s, bus.wdata_b, xa_s);
    pb1_s     = merge_w(mem_r[bus.addr_b], bus.wdata_a, xb_s);
    post_b_s  = merge_w(pb1_s, bus.wdata_b, eff_b_s);
    coll_d_s  = same_s && (|(ma_s & mb_s));
    rd_a_en_s = ready_s && bus.re_a;
    rd_b_en_s = ready_s && bus.re_b;
  end

  // Array update: clear engine owns the array while not ready. On a
  // same-address write both ports carry the identical merged word.
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_r[clr_addr_s] <= CLR_VALUE;
    end else begin
      if (|eff_a_s) begin
        mem_r[bus.addr_a] <= post_a_s;
      end
      if (|eff_b_s) begin
        mem_r[bus.addr_b] <= post_b_s;
      end
    end
  end

  // Read register and collision pulse; rdata holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a_r  <= {WIDTH{1'b0}};
      rdata_b_r  <= {WIDTH{1'b0}};
      rvalid_a_r <= 1'b0;
      rvalid_b_r <= 1'b0;
      coll_r     <= 1'b0;
    end else begin
      rvalid_a_r <= rd_a_en_s;
      rvalid_b_r <= rd_b_en_s;
      coll_r     <= coll_d_s;
      if (rd_a_en_s) begin
        rdata_a_r <= post_a_s;
      end
      if (rd_b_en_s) begin
        rdata_b_r <= post_b_s;
      end
    end
  end

`ifdef DPRAM_OUTREG_EN
  logic [WIDTH-1:0] rdata_a_o_r;
  logic [WIDTH-1:0] rdata_b_o_r;
  logic             rvalid_a_o_r;
  logic             rvalid_b_o_r;

  // Output register stage; data only advances with a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a_o_r  <= {WIDTH{1'b0}};
      rdata_b_o_r  <= {WIDTH{1'b0}};
      rvalid_a_o_r <= 1'b0;
      rvalid_b_o_r <= 1'b0;
    end else begin
      rvalid_a_o_r <= rvalid_a_r;
      rvalid_b_o_r <= rvalid_b_r;
      if (rvalid_a_r) begin
        rdata_a_o_r <= rdata_a_r;
      end
      if (rvalid_b_r) begin
        rdata_b_o_r <= rdata_b_r;
      end
    end
  end

  assign bus.rdata_a  = rdata_a_o_r;
  assign bus.rdata_b  = rdata_b_o_r;
  assign bus.rvalid_a = rvalid_a_o_r;
  assign bus.rvalid_b = rvalid_b_o_r;
`else
  assign bus.rdata_a  = rdata_a_r;
  assign bus.rdata_b  = rdata_b_r;
  assign bus.rvalid_a = rvalid_a_r;
  assign bus.rvalid_b = rvalid_b_r;
`endif

  assign bus.coll  = coll_r;
  assign bus.ready = ready_s;

endmodule

// File: tb/tb_dpram_be_clr.sv
// Bench for dpram_be_clr: two instances (PRIO_B=0, CLR_VALUE=0 and
// PRIO_B=1, CLR_VALUE=0x5A5A) driven with identical stimulus and compared
// every cycle against a memory-array reference model, plus a vector table
// and directed clear/reset sequences.
module tb_dpram_be_clr;

  typedef struct packed {
    logic [3:0]  addr_a;
    logic        we_a;
    logic [1:0]  be_a;
    logic [15:0] wdata_a;
    logic        re_a;
    logic [3:0]  addr_b;
    logic        we_b;
    logic [1:0]  be_b;
    logic [15:0] wdata_b;
    logic        re_b;
    logic        clr_req;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        coll_e;
    logic        va_e;
    logic [15:0] da0;
    logic [15:0] da1;
    logic        vb_e;
    logic [15:0] db0;
    logic [15:0] db1;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dpram_be_clr_if #(.WIDTH(16), .DEPTHBIT(4)) bus0 ();
  dpram_be_clr_if #(.WIDTH(16), .DEPTHBIT(4)) bus1 ();

  dpram_be_clr #(.WIDTH(16), .DEPTHBIT(4), .PRIO_B(0), .CLR_VALUE(16'h0000))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  dpram_be_clr #(.WIDTH(16), .DEPTHBIT(4), .PRIO_B(1), .CLR_VALUE(16'h5A5A))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks = 0;
  int errors = 0;

  // Reference model state per instance
  logic [15:0] clrv [2] = '{16'h0000, 16'h5A5A};
  bit          prio [2] = '{1'b0, 1'b1};
  logic [15:0] mem_m [2][16];
  bit          clr_m [2];
  int          cnt_m [2];
  logic        s1v_a [2], s1v_b [2], s2v_a [2], s2v_b [2], coll_m [2];
  logic [15:0] s1d_a [2], s1d_b [2], s2d_a [2], s2d_b [2];

  // Sampled DUT outputs
  logic        act_rdy [2], act_va [2], act_vb [2], act_coll [2];
  logic [15:0] act_da [2], act_db [2];

  stim_t idle_s = '0;

  task automatic chk(input string nm, input int d, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h", nm, d, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    bus0.addr_a = s.addr_a; bus0.we_a = s.we_a; bus0.be_a = s.be_a; bus0.wdata_a = s.wdata_a; bus0.re_a = s.re_a;
    bus0.addr_b = s.addr_b; bus0.we_b = s.we_b; bus0.be_b = s.be_b; bus0.wdata_b = s.wdata_b; bus0.re_b = s.re_b;
    bus0.clr_req = s.clr_req;
    bus1.addr_a = s.addr_a; bus1.we_a = s.we_a; bus1.be_a = s.be_a; bus1.wdata_a = s.wdata_a; bus1.re_a = s.re_a;
    bus1.addr_b = s.addr_b; bus1.we_b = s.we_b; bus1.be_b = s.be_b; bus1.wdata_b = s.wdata_b; bus1.re_b = s.re_b;
    bus1.clr_req = s.clr_req;
  endtask

  task automatic sample();
    act_rdy[0] = bus0.ready; act_va[0] = bus0.rvalid_a; act_vb[0] = bus0.rvalid_b;
    act_coll[0] = bus0.coll; act_da[0] = bus0.rdata_a; act_db[0] = bus0.rdata_b;
    act_rdy[1] = bus1.ready; act_va[1] = bus1.rvalid_a; act_vb[1] = bus1.rvalid_b;
    act_coll[1] = bus1.coll; act_da[1] = bus1.rdata_a; act_db[1] = bus1.rdata_b;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      clr_m[d] = 1'b1; cnt_m[d] = 0; coll_m[d] = 1'b0;
      s1v_a[d] = 1'b0; s1v_b[d] = 1'b0; s2v_a[d] = 1'b0; s2v_b[d] = 1'b0;
      s1d_a[d] = 16'h0000; s1d_b[d] = 16'h0000; s2d_a[d] = 16'h0000; s2d_b[d] = 16'h0000;
    end
  endtask

  task automatic wr(input int d, input logic [3:0] a, input logic we, input logic [1:0] be, input logic [15:0] wd);
    if (we) begin
      for (int i = 0; i < 2; i++) begin
        if (be[i]) mem_m[d][a][8*i +: 8] = wd[8*i +: 8];
      end
    end
  endtask

  // One rising edge of the specified behaviour: the priority port is
  // written last so it owns shared bytes, then reads see the result.
  task automatic model_edge(input stim_t s);
    for (int d = 0; d < 2; d++) begin
      s2v_a[d] = s1v_a[d]; if (s1v_a[d]) s2d_a[d] = s1d_a[d];
      s2v_b[d] = s1v_b[d]; if (s1v_b[d]) s2d_b[d] = s1d_b[d];
      if (clr_m[d]) begin
        mem_m[d][cnt_m[d]] = clrv[d];
        if (cnt_m[d] == 15) clr_m[d] = 1'b0;
        else cnt_m[d] = cnt_m[d] + 1;
        s1v_a[d] = 1'b0; s1v_b[d] = 1'b0; coll_m[d] = 1'b0;
      end else begin
        coll_m[d] = s.we_a && s.we_b && (s.addr_a == s.addr_b) && ((s.be_a & s.be_b) != 2'b00);
        if (prio[d]) begin
          wr(d, s.addr_a, s.we_a, s.be_a, s.wdata_a);
          wr(d, s.addr_b, s.we_b, s.be_b, s.wdata_b);
        end else begin
          wr(d, s.addr_b, s.we_b, s.be_b, s.wdata_b);
          wr(d, s.addr_a, s.we_a, s.be_a, s.wdata_a);
        end
        s1v_a[d] = s.re_a; if (s.re_a) s1d_a[d] = mem_m[d][s.addr_a];
        s1v_b[d] = s.re_b; if (s.re_b) s1d_b[d] = mem_m[d][s.addr_b];
        if (s.clr_req) begin clr_m[d] = 1'b1; cnt_m[d] = 0; end
      end
    end
  endtask

  task automatic chk_all();
    logic ev_a, ev_b;
    logic [15:0] ed_a, ed_b;
    for (int d = 0; d < 2; d++) begin
`ifdef DPRAM_OUTREG_EN
      ev_a = s2v_a[d]; ev_b = s2v_b[d]; ed_a = s2d_a[d]; ed_b = s2d_b[d];
`else
      ev_a = s1v_a[d]; ev_b = s1v_b[d]; ed_a = s1d_a[d]; ed_b = s1d_b[d];
`endif
      chk("ready", d, {15'd0, act_rdy[d]}, {15'd0, ~clr_m[d]});
      chk("rvalid_a", d, {15'd0, act_va[d]}, {15'd0, ev_a});
      chk("rvalid_b", d, {15'd0, act_vb[d]}, {15'd0, ev_b});
      chk("coll", d, {15'd0, act_coll[d]}, {15'd0, coll_m[d]});
      chk("rdata_a", d, act_da[d], ed_a);
      chk("rdata_b", d, act_db[d], ed_b);
    end
  endtask

  task automatic step(input stim_t s);
    drive(s);
    @(posedge clk);
    #1;
    model_edge(s);
    sample();
    chk_all();
  endtask

  function automatic stim_t rand_stim(input int clr_den);
    stim_t s;
    bit narrow;
    narrow = ($urandom_range(0, 1) == 1);
    s.addr_a  = narrow ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15));
    s.addr_b  = narrow ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15));
    s.we_a    = 1'($urandom_range(0, 1));
    s.we_b    = 1'($urandom_range(0, 1));
    s.be_a    = 2'($urandom_range(0, 3));
    s.be_b    = 2'($urandom_range(0, 3));
    s.wdata_a = 16'($urandom);
    s.wdata_b = 16'($urandom);
    s.re_a    = 1'($urandom_range(0, 1));
    s.re_b    = 1'($urandom_range(0, 1));
    s.clr_req = (clr_den > 0) && ($urandom_range(0, clr_den - 1) == 0);
    return s;
  endfunction

  function automatic vec_t mk(input logic [3:0] aa, input logic wea, input logic [1:0] bea,
                              input logic [15:0] wda, input logic rea,
                              input logic [3:0] ab, input logic web, input logic [1:0] beb,
                              input logic [15:0] wdb, input logic reb, input logic ce,
                              input logic va, input logic [15:0] da0, input logic [15:0] da1,
                              input logic vb, input logic [15:0] db0, input logic [15:0] db1);
    vec_t v;
    v.s = '{addr_a: aa, we_a: wea, be_a: bea, wdata_a: wda, re_a: rea,
            addr_b: ab, we_b: web, be_b: beb, wdata_b: wdb, re_b: reb, clr_req: 1'b0};
    v.coll_e = ce; v.va_e = va; v.da0 = da0; v.da1 = da1;
    v.vb_e = vb; v.db0 = db0; v.db1 = db1;
    return v;
  endfunction

  // Steps until ready rises; n is the number of edges taken (capped).
  task automatic count_clear(output int n, input int clr_den);
    n = 0;
    while (!bus0.ready && n < 40) begin
      step(rand_stim(clr_den));
      n++;
    end
  endtask

  task automatic read_all();
    stim_t s;
    for (int a = 0; a < 16; a++) begin
      s = idle_s;
      s.re_a = 1'b1; s.addr_a = 4'(a);
      s.re_b = 1'b1; s.addr_b = 4'(15 - a);
      step(s);
    end
    step(idle_s);
  endtask

  initial begin
    vec_t  vecs [10];
    stim_t s;
    int    n;

    vecs[0] = mk(4'd3, 1'b1, 2'b11, 16'hBEEF, 1'b0, 4'd0, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0,
                 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    vecs[1] = mk(4'd0, 1'b0, 2'b00, 16'h0000, 1'b0, 4'd3, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0,
                 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 16'hBEEF);
    vecs[2] = mk(4'd5, 1'b1, 2'b11, 16'h1111, 1'b0, 4'd5, 1'b1, 2'b10, 16'h2222, 1'b0, 1'b1,
                 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    vecs[3] = mk(4'd5, 1'b0, 2'b00, 16'h0000, 1'b1, 4'd0, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0,
                 1'b1, 16'h1111, 16'h2211, 1'b0, 16'h0000, 16'h0000);
    vecs[4] = mk(4'd7, 1'b1, 2'b01, 16'hAAAA, 1'b0, 4'd7, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0,
                 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h00AA, 16'h5AAA);
    vecs[5] = mk(4'd9, 1'b1, 2'b10, 16'h1234, 1'b0, 4'd9, 1'b1, 2'b01, 16'hABCD, 1'b0, 1'b0,
                 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    vecs[6] = mk(4'd9, 1'b0, 2'b00, 16'h0000, 1'b1, 4'd3, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0,
                 1'b1, 16'h12CD, 16'h12CD, 1'b1, 16'hBEEF, 16'hBEEF);
    vecs[7] = mk(4'd2, 1'b1, 2'b00, 16'hFFFF, 1'b1, 4'd0, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0,
                 1'b1, 16'h0000, 16'h5A5A, 1'b0, 16'h0000, 16'h0000);
    vecs[8] = mk(4'd4, 1'b1, 2'b11, 16'hC0DE, 1'b1, 4'd4, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0,
                 1'b1, 16'hC0DE, 16'hC0DE, 1'b1, 16'hC0DE, 16'hC0DE);
    vecs[9] = mk(4'd6, 1'b1, 2'b01, 16'h00FF, 1'b1, 4'd6, 1'b1, 2'b11, 16'h1357, 1'b1, 1'b1,
                 1'b1, 16'h13FF, 16'h1357, 1'b1, 16'h13FF, 16'h1357);

    // Power-up reset and first clear
    rst_n = 1'b0;
    drive(idle_s);
    model_reset();
    @(posedge clk);
    #1;
    sample();
    chk_all();
    rst_n = 1'b1;
    count_clear(n, 0);
    chk("clear_len_reset", 0, 16'(n), 16'd16);
    read_all();

    // Directed vector table
    foreach (vecs[i]) begin
      step(vecs[i].s);
      chk("vec_coll", i, {15'd0, bus0.coll}, {15'd0, vecs[i].coll_e});
      chk("vec_coll", i, {15'd0, bus1.coll}, {15'd0, vecs[i].coll_e});
`ifdef DPRAM_OUTREG_EN
      step(idle_s);
`endif
      chk("vec_rvalid_a", i, {15'd0, bus0.rvalid_a}, {15'd0, vecs[i].va_e});
      chk("vec_rvalid_b", i, {15'd0, bus1.rvalid_b}, {15'd0, vecs[i].vb_e});
      if (vecs[i].va_e) begin
        chk("vec_rdata_a0", i, bus0.rdata_a, vecs[i].da0);
        chk("vec_rdata_a1", i, bus1.rdata_a, vecs[i].da1);
      end
      if (vecs[i].vb_e) begin
        chk("vec_rdata_b0", i, bus0.rdata_b, vecs[i].db0);
        chk("vec_rdata_b1", i, bus1.rdata_b, vecs[i].db1);
      end
    end

    // Randomized traffic, occasional clear requests
    for (int k = 0; k < 600; k++) begin
      step(rand_stim(50));
    end
    count_clear(n, 0);
    chk("ready_after_random", 0, {15'd0, bus0.ready}, 16'd1);

    // Fill, then clear with a read on the last ready cycle and traffic during the clear
    for (int a = 0; a < 16; a++) begin
      s = idle_s;
      s.we_a = 1'b1; s.be_a = 2'b11; s.addr_a = 4'(a); s.wdata_a = 16'($urandom) | 16'h0101;
      s.re_b = 1'b1; s.addr_b = 4'(a);
      step(s);
    end
    s = idle_s;
    s.clr_req = 1'b1; s.re_a = 1'b1; s.addr_a = 4'd9; s.re_b = 1'b1; s.addr_b = 4'd2;
    step(s);
    count_clear(n, 3);
    chk("clear_len_req", 0, 16'(n), 16'd16);
    read_all();

    // Fill again, start a clear and reset it at counter 8
    for (int a = 0; a < 16; a++) begin
      s = idle_s;
      s.we_b = 1'b1; s.be_b = 2'b11; s.addr_b = 4'(a); s.wdata_b = 16'($urandom) | 16'h0101;
      s.re_a = 1'b1; s.addr_a = 4'(a);
      step(s);
    end
    s = idle_s;
    s.clr_req = 1'b1; s.re_a = 1'b1; s.addr_a = 4'd5; s.re_b = 1'b1; s.addr_b = 4'd6;
    step(s);
    for (int k = 0; k < 8; k++) begin
      step(idle_s);
    end
    chk("mid_clear_cnt", 0, 16'(cnt_m[0]), 16'd8);
    rst_n = 1'b0;
    #1;
    model_reset();
    sample();
    chk_all();
    @(posedge clk);
    #1;
    sample();
    chk_all();
    rst_n = 1'b1;
    count_clear(n, 0);
    chk("clear_len_rerun", 0, 16'(n), 16'd16);
    read_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
